// File: rtl/lock_sequencer_if.sv
// rtl/lock_sequencer_if.sv - pad inputs and status LED bundle between the lock pads and lock_sequencer
interface lock_sequencer_if;
    logic [3:0] in_digit;
    logic       enter_btn;
    logic       prog_en;
    logic       locked_led;
    logic       unlocked_led;
    logic       error_led;
    logic       lockout_led;
    logic [2:0] state_leds;
    logic [3:0] digit_count;
    logic [3:0] fail_count;

    modport master (
        output in_digit, enter_btn, prog_en,
        input  locked_led, unlocked_led, error_led, lockout_led,
               state_leds, digit_count, fail_count
    );

    modport slave (
        input  in_digit, enter_btn, prog_en,
        output locked_led, unlocked_led, error_led, lockout_led,
               state_leds, digit_count, fail_count
    );
endinterface

// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - combination-lock controller: enter sync, code entry/compare, timers, LEDs
module lock_sequencer #(
    parameter int                      NUM_DIGITS     = 4,
    parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                      MAX_FAILS      = 3,
    parameter int                      ERROR_CYCLES   = 8,
    parameter int                      LOCKOUT_CYCLES = 1000,
    parameter int                      UNLOCK_CYCLES  = 500,
    parameter int                      ENTRY_TIMEOUT  = 1000
) (
    input  logic              clk,
    input  logic              reset,
    lock_sequencer_if.slave   bus
);
    localparam int CW    = 4 * NUM_DIGITS;
    localparam int TM_A  = (ERROR_CYCLES > LOCKOUT_CYCLES) ? ERROR_CYCLES : LOCKOUT_CYCLES;
    localparam int TM_B  = (UNLOCK_CYCLES > ENTRY_TIMEOUT) ? UNLOCK_CYCLES : ENTRY_TIMEOUT;
    localparam int TMAX  = (TM_A > TM_B) ? TM_A : TM_B;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        LOCKED   = 3'b000,
        ENTRY    = 3'b001,
        CHECK    = 3'b010,
        UNLOCKED = 3'b011,
        ERROR    = 3'b100,
        LOCKOUT  = 3'b101,
        PROGRAM  = 3'b110
    } state_t;

    // Timer loads hold N-1 so a state loaded with N spans exactly N cycles.
    localparam logic [TW-1:0] T_ENTRY   = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [TW-1:0] T_ERROR   = TW'(ERROR_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYCLES - 1);

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [3:0]      digit_count, count_n;
    logic [3:0]      fail_count, fails_n;
    logic [CW-1:0]   buffer, buffer_n;
    logic [CW-1:0]   code, code_n;

    logic            enter_s1, enter_s2, enter_s3;
    logic [3:0]      digit_s1, digit_s2;
    logic            press;
    logic            expired;
    logic [CW-1:0]   shifted;
    logic [3:0]      count_inc;
    logic [3:0]      fails_inc;
    logic            last_digit;

    assign press      = enter_s2 & ~enter_s3;
    assign expired    = (timer == '0);
    assign shifted    = CW'({buffer, digit_s2});
    assign count_inc  = digit_count + 4'd1;
    assign fails_inc  = fail_count + 4'd1;
    assign last_digit = (count_inc == 4'(NUM_DIGITS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOCKED;
            timer       <= '0;
            digit_count <= '0;
            fail_count  <= '0;
            buffer      <= '0;
            code        <= DEFAULT_CODE;
            enter_s1    <= 1'b0;
            enter_s2    <= 1'b0;
            enter_s3    <= 1'b0;
            digit_s1    <= '0;
            digit_s2    <= '0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            digit_count <= count_n;
            fail_count  <= fails_n;
            buffer      <= buffer_n;
            code        <= code_n;
            enter_s1    <= bus.enter_btn;
            enter_s2    <= enter_s1;
            enter_s3    <= enter_s2;
            digit_s1    <= bus.in_digit;
            digit_s2    <= digit_s1;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = expired ? timer : timer - TW'(1);
        count_n  = digit_count;
        fails_n  = fail_count;
        buffer_n = buffer;
        code_n   = code;
        case (state)
            LOCKED, ENTRY, PROGRAM: begin
                // LOCKED enters with digit_count=0, so it shares the digit-accept path.
                if (press) begin
                    buffer_n = shifted;
                    count_n  = count_inc;
                    timer_n  = T_ENTRY;
                    if (!last_digit) begin
                        state_n = (state == PROGRAM) ? PROGRAM : ENTRY;
                    end else if (state == PROGRAM) begin
                        code_n   = shifted;
                        state_n  = LOCKED;
                        count_n  = '0;
                        buffer_n = '0;
                    end else begin
                        state_n = CHECK;
                    end
                end else if (state != LOCKED && expired) begin
                    state_n  = LOCKED;
                    count_n  = '0;
                    buffer_n = '0;
                end
            end
            CHECK: begin
                count_n = '0;
                if (buffer == code) begin
                    state_n = UNLOCKED;
                    fails_n = '0;
                    timer_n = T_UNLOCK;
                end else begin
                    fails_n = fails_inc;
                    if (fails_inc == 4'(MAX_FAILS)) begin
                        state_n = LOCKOUT;
                        timer_n = T_LOCKOUT;
                    end else begin
                        state_n = ERROR;
                        timer_n = T_ERROR;
                    end
                end
            end
            UNLOCKED: begin
                if (press) begin
                    if (bus.prog_en) begin
                        state_n  = PROGRAM;
                        count_n  = '0;
                        buffer_n = '0;
                        timer_n  = T_ENTRY;
                    end else begin
                        state_n = LOCKED;
                    end
                end else if (expired) begin
                    state_n = LOCKED;
                end
            end
            ERROR: begin
                if (expired) state_n = LOCKED;
            end
            LOCKOUT: begin
                if (expired) begin
                    state_n = LOCKED;
                    fails_n = '0;
                end
            end
            default: state_n = LOCKED;
        endcase
    end

    assign bus.state_leds   = state;
    assign bus.unlocked_led = (state == UNLOCKED);
    assign bus.locked_led   = (state == LOCKED) || (state == ENTRY) || (state == CHECK) ||
                              (state == ERROR)  || (state == LOCKOUT) || (state == PROGRAM);
    assign bus.error_led    = (state == ERROR) || (state == LOCKOUT);
    assign bus.lockout_led  = (state == LOCKOUT);
    assign bus.digit_count  = digit_count;
    assign bus.fail_count   = fail_count;
endmodule
